// File: rtl/pmp_seq_checker_if.sv
// Request/response bundle of the sequential PMP checker.
// master = requester side, slave = checker side.
interface pmp_seq_checker_if #(
    parameter int PLEN       = 56,
    parameter int NR_ENTRIES = 16
);
    localparam int EW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

    logic            req_valid;
    logic            req_ready;
    logic [PLEN-1:0] req_addr;
    logic [2:0]      req_access;
    logic [1:0]      req_priv;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_allow;
    logic            rsp_match;
    logic [EW-1:0]   rsp_entry;

    modport master (
        output req_valid, req_addr, req_access, req_priv, rsp_ready,
        input  req_ready, rsp_valid, rsp_allow, rsp_match, rsp_entry
    );

    modport slave (
        input  req_valid, req_addr, req_access, req_priv, rsp_ready,
        output req_ready, rsp_valid, rsp_allow, rsp_match, rsp_entry
    );
endinterface

// File: rtl/pmp_seq_checker.sv
// Multi-cycle PMP checker: one shared address comparator scans entries 0..N-1.
// Optional macro PMP_SEQ_BYPASS_M_EN: M-mode requests skip the scan when no entry is locked.
module pmp_entry #(
    parameter int PLEN    = 56,
    parameter int PMP_LEN = 54
) (
    input  logic [PLEN-1:0]    addr_i,
    input  logic [PMP_LEN-1:0] conf_addr_i,
    input  logic [PMP_LEN-1:0] conf_addr_prev_i,
    input  logic [1:0]         mode_i,
    output logic               match_o
);
    localparam int W = (PLEN > PMP_LEN + 2) ? PLEN : PMP_LEN + 2;

    logic [W-1:0]       addr_w;
    logic [W-1:0]       base_w;
    logic [W-1:0]       prev_w;
    logic [W-1:0]       napot_mask_w;
    logic [PMP_LEN-1:0] napot_mask;

    assign addr_w = W'(addr_i);
    assign base_w = W'({conf_addr_i, 2'b00});
    assign prev_w = W'({conf_addr_prev_i, 2'b00});

    // x ^ (x+1) sets the trailing-ones run plus the first zero: the NAPOT size in words
    assign napot_mask   = conf_addr_i ^ (conf_addr_i + PMP_LEN'(1));
    assign napot_mask_w = W'({napot_mask, 2'b11});

    always_comb begin
        match_o = 1'b0;
        case (mode_i)
            2'd1:    match_o = (addr_w >= prev_w) && (addr_w < base_w);
            2'd2:    match_o = (addr_w[W-1:2] == base_w[W-1:2]);
            2'd3:    match_o = (((addr_w ^ base_w) & ~napot_mask_w) == '0);
            default: match_o = 1'b0;
        endcase
    end
endmodule

module pmp_seq_checker #(
    parameter int PLEN       = 56,
    parameter int PMP_LEN    = 54,
    parameter int NR_ENTRIES = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 kill_i,
    pmp_seq_checker_if.slave                     bus,
    input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]   conf_addr_i,
    input  logic [NR_ENTRIES-1:0][7:0]           conf_i
);
    localparam int          IW       = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NR_ENTRIES - 1);
    localparam logic [1:0]  PRIV_M   = 2'b11;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [PLEN-1:0]   addr_q, addr_d;
    logic [2:0]        access_q, access_d;
    logic [1:0]        priv_q, priv_d;
    logic              allow_q, allow_d;
    logic              match_q, match_d;
    logic [IW-1:0]     entry_q, entry_d;

    logic              cfg_lock;
    logic [1:0]        cfg_mode;
    logic [2:0]        cfg_access;
    logic [PMP_LEN-1:0] cur_addr;
    logic [PMP_LEN-1:0] prev_addr;
    logic              entry_match;
    logic              accept;

    assign cfg_lock   = conf_i[idx_q][7];
    assign cfg_mode   = conf_i[idx_q][4:3];
    assign cfg_access = conf_i[idx_q][2:0];
    assign cur_addr   = conf_addr_i[idx_q];
    assign prev_addr  = (idx_q == '0) ? '0 : conf_addr_i[idx_q - IW'(1)];

    pmp_entry #(
        .PLEN    (PLEN),
        .PMP_LEN (PMP_LEN)
    ) u_entry (
        .addr_i           (addr_q),
        .conf_addr_i      (cur_addr),
        .conf_addr_prev_i (prev_addr),
        .mode_i           (cfg_mode),
        .match_o          (entry_match)
    );

`ifdef PMP_SEQ_BYPASS_M_EN
    logic [NR_ENTRIES-1:0] lock_bits;
    logic                  any_lock;

    generate
        for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_lock
            assign lock_bits[gi] = conf_i[gi][7];
        end
    endgenerate

    assign any_lock = |lock_bits;
`endif

    assign bus.req_ready = (state_q == IDLE) && !kill_i;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        access_d = access_q;
        priv_d   = priv_q;
        allow_d  = allow_q;
        match_d  = match_q;
        entry_d  = entry_q;

        if (kill_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_d   = bus.req_addr;
                        access_d = bus.req_access;
                        priv_d   = bus.req_priv;
                        idx_d    = '0;
                        state_d  = SCAN;
`ifdef PMP_SEQ_BYPASS_M_EN
                        if ((bus.req_priv == PRIV_M) && !any_lock) begin
                            state_d = RESP;
                            allow_d = 1'b1;
                            match_d = 1'b0;
                            entry_d = '0;
                        end
`endif
                    end
                end
                SCAN: begin
                    if (entry_match) begin
                        state_d = RESP;
                        match_d = 1'b1;
                        entry_d = idx_q;
                        // unlocked entries never restrict M-mode
                        allow_d = ((priv_q == PRIV_M) && !cfg_lock) ? 1'b1
                                : ((access_q & cfg_access) == access_q);
                    end else if (idx_q == LAST_IDX) begin
                        state_d = RESP;
                        allow_d = (priv_q == PRIV_M);
                        match_d = 1'b0;
                        entry_d = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            access_q <= '0;
            priv_q   <= '0;
            allow_q  <= 1'b0;
            match_q  <= 1'b0;
            entry_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            access_q <= access_d;
            priv_q   <= priv_d;
            allow_q  <= allow_d;
            match_q  <= match_d;
            entry_q  <= entry_d;
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_allow = allow_q;
    assign bus.rsp_match = match_q;
    assign bus.rsp_entry = entry_q;
endmodule

// File: tb/tb_pmp_seq_checker.sv
// Directed bench for pmp_seq_checker: NAPOT/TOR/OFF configs, latency, backpressure, kill, reset.
module tb_pmp_seq_checker;
    localparam logic [2:0] ACC_R = 3'b001;
    localparam logic [2:0] ACC_W = 3'b010;
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic kill = 1'b0;
    logic [15:0][53:0] conf_addr;
    logic [15:0][7:0]  conf;

    int n_checks = 0;
    int n_fail   = 0;

    pmp_seq_checker_if #(.PLEN(56), .NR_ENTRIES(16)) bus ();

    pmp_seq_checker #(
        .PLEN       (56),
        .PMP_LEN    (54),
        .NR_ENTRIES (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .kill_i      (kill),
        .bus         (bus),
        .conf_addr_i (conf_addr),
        .conf_i      (conf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 16; i++) begin
            conf_addr[i] = '0;
            conf[i]      = '0;
        end
    endtask

    // latency counted as in the timing notation: 1 = valid right after the accept edge
    task automatic run_req(input string tag, input logic [55:0] addr, input logic [2:0] acc,
                           input logic [1:0] priv, input int exp_lat, input logic exp_allow,
                           input logic exp_match, input logic [3:0] exp_entry);
        int lat;
        @(negedge clk);
        check_eq({tag, "_rdy"}, bus.req_ready, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_access = acc;
        bus.req_priv   = priv;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("txn %s addr=0x%0h acc=%0d priv=%0d lat=%0d allow=%0b match=%0b entry=%0d",
                 tag, addr, acc, priv, lat, bus.rsp_allow, bus.rsp_match, bus.rsp_entry);
        check_eq({tag, "_lat"},   lat,           exp_lat);
        check_eq({tag, "_allow"}, bus.rsp_allow, exp_allow);
        check_eq({tag, "_match"}, bus.rsp_match, exp_match);
        check_eq({tag, "_entry"}, bus.rsp_entry, exp_entry);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic start_req(input logic [55:0] addr, input logic [2:0] acc, input logic [1:0] priv);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_access = acc;
        bus.req_priv   = priv;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic set_napot3(input logic lock);
        clear_cfg();
        conf_addr[3] = 54'h2000_01FF;           // 0x8000_0000, 4 KiB
        conf[3]      = {lock, 7'h19};           // NAPOT, R only
    endtask

    initial begin
        int seen;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_access = '0;
        bus.req_priv   = '0;
        bus.rsp_ready  = 1'b0;
        clear_cfg();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", bus.rsp_valid, 1'b0);
        check_eq("rst_allow", bus.rsp_allow, 1'b0);
        check_eq("rst_match", bus.rsp_match, 1'b0);
        check_eq("rst_entry", bus.rsp_entry, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_ready", bus.req_ready, 1'b1);

        // NAPOT entry 3
        set_napot3(1'b0);
        run_req("napot_u_rd", 56'h8000_0010, ACC_R, PRIV_U, 5, 1'b1, 1'b1, 4'd3);
        run_req("napot_u_wr", 56'h8000_0010, ACC_W, PRIV_U, 5, 1'b0, 1'b1, 4'd3);
        run_req("napot_u_out", 56'h8000_1000, ACC_R, PRIV_U, 17, 1'b0, 1'b0, 4'd0);
`ifdef PMP_SEQ_BYPASS_M_EN
        run_req("napot_m_wr", 56'h8000_0010, ACC_W, PRIV_M, 1, 1'b1, 1'b0, 4'd0);
`else
        run_req("napot_m_wr", 56'h8000_0010, ACC_W, PRIV_M, 5, 1'b1, 1'b1, 4'd3);
`endif
        set_napot3(1'b1);
        run_req("napot_m_wr_lock", 56'h8000_0010, ACC_W, PRIV_M, 5, 1'b0, 1'b1, 4'd3);

        // all entries OFF
        clear_cfg();
        run_req("off_s_rd", 56'h1000, ACC_R, PRIV_S, 17, 1'b0, 1'b0, 4'd0);
`ifdef PMP_SEQ_BYPASS_M_EN
        run_req("off_m_rd", 56'h1000, ACC_R, PRIV_M, 1, 1'b1, 1'b0, 4'd0);
`else
        run_req("off_m_rd", 56'h1000, ACC_R, PRIV_M, 17, 1'b1, 1'b0, 4'd0);
`endif

        // TOR entry 1: [0x1000, 0x2000)
        clear_cfg();
        conf_addr[0] = 54'h400;
        conf_addr[1] = 54'h800;
        conf[1]      = 8'h0B;
        run_req("tor_top",   56'h1FFC, ACC_R, PRIV_S, 3, 1'b1, 1'b1, 4'd1);
        run_req("tor_above", 56'h2000, ACC_R, PRIV_S, 17, 1'b0, 1'b0, 4'd0);
        run_req("tor_base",  56'h1000, ACC_R, PRIV_S, 3, 1'b1, 1'b1, 4'd1);
        run_req("tor_below", 56'h0FFC, ACC_W, PRIV_S, 17, 1'b0, 1'b0, 4'd0);

        // backpressure: hold rsp_ready low for 5 cycles
        set_napot3(1'b0);
        start_req(56'h8000_0010, ACC_R, PRIV_U);
        seen = 0;
        while (!bus.rsp_valid && seen < 40) begin
            @(posedge clk); #1;
            seen++;
        end
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", bus.rsp_valid, 1'b1);
            check_eq("bp_allow", bus.rsp_allow, 1'b1);
            check_eq("bp_match", bus.rsp_match, 1'b1);
            check_eq("bp_entry", bus.rsp_entry, 4'd3);
            check_eq("bp_ready", bus.req_ready, 1'b0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        $display("txn backpressure done valid=%0b ready=%0b", bus.rsp_valid, bus.req_ready);
        check_eq("bp_done_valid", bus.rsp_valid, 1'b0);
        check_eq("bp_done_ready", bus.req_ready, 1'b1);

        // kill at scan index 2 (no match anywhere, so a missed kill would respond later)
        clear_cfg();
        start_req(56'h1000, ACC_R, PRIV_S);
        repeat (2) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        #1;
        check_eq("kill_ready_low", bus.req_ready, 1'b0);
        @(posedge clk); #1;
        kill = 1'b0;
        #1;
        check_eq("kill_valid", bus.rsp_valid, 1'b0);
        check_eq("kill_ready", bus.req_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1;
        end
        $display("txn kill done rsp_seen=%0d", seen);
        check_eq("kill_no_rsp", seen, 0);
        if (bus.rsp_valid) begin
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
        end

        // reset during SCAN; result registers still hold the entry-3 response
        start_req(56'h1000, ACC_R, PRIV_S);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", bus.rsp_valid, 1'b0);
        check_eq("arst_allow", bus.rsp_allow, 1'b0);
        check_eq("arst_match", bus.rsp_match, 1'b0);
        check_eq("arst_entry", bus.rsp_entry, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_napot3(1'b0);
        run_req("post_rst", 56'h8000_0FFC, ACC_R, PRIV_U, 5, 1'b1, 1'b1, 4'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
